exec_result_buffer: RTL and testbench

Execute-to-writeback stage sitting directly downstream of the ALU. Captures each ALU result with its `zero`/`negative` flags and destination tag into a 2-entry skid buffer under a valid/ready handshake, and presents entries in order to the register-file write port. Holds the architectural status flags, updated at retirement, and counts retired operations.

---
 rtl/exec_pkg.sv | 25 ++
 rtl/exec_entry_reg.sv | 38 +++
 rtl/exec_result_buffer.sv | 167 ++++++++++++++++
 tb/tb_exec_result_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared types for the execute-to-writeback result buffer.
//   DATA_W / DEST_W : result and register-file address widths
//   buf_state_e     : buffer occupancy (EMPTY / ONE / TWO)
//   entry_t         : one buffered ALU result with its flags and tag
package exec_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEST_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              negative;
        logic [DEST_W-1:0] dest;
        logic              wr_en;
        logic              flags_en;
    } entry_t;

endpackage

// File: rtl/exec_entry_reg.sv
// exec_entry_reg: load-enable register holding one buffer entry.
//   clock : rising-edge clock
//   reset : asynchronous active-low clear
//   load  : capture d on the next edge
//   d     : entry to capture
//   q     : stored entry
module exec_entry_reg
    import exec_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   load,
    input  entry_t d,
    output entry_t q
);

    entry_t entry_q;
    entry_t entry_d;

    // Hold unless loaded
    always_comb begin
        entry_d = entry_q;
        if (load) begin
            entry_d = d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/exec_result_buffer.sv
// exec_result_buffer: 2-entry skid buffer between the ALU and the
// register-file write port, plus architectural zero/negative flags and
// a retired-operation counter.
//   clock, reset                 : rising-edge clock, async active-low reset
//   in_valid/in_ready            : upstream handshake (in_ready registered)
//   in_result..in_flags_en       : entry fields captured verbatim on push
//   flush                        : synchronous discard of all entries
//   out_valid/out_ready          : downstream handshake on the head entry
//   out_result/out_dest/out_wr_en: head entry fields
//   flag_zero/flag_negative      : status flags updated on retirement
//   retire_count                 : wrapping count of retired entries
module exec_result_buffer
    import exec_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic              in_negative,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic              in_flags_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_wr_en,
    output logic              flag_zero,
    output logic              flag_negative,
    output logic [CNT_W-1:0]  retire_count
);

    buf_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             flag_zero_q, flag_zero_d;
    logic             flag_negative_q, flag_negative_d;
    logic [CNT_W-1:0] retire_count_q, retire_count_d;

    logic   push;
    logic   pop;
    logic   head_load;
    logic   skid_load;
    entry_t head_in;
    entry_t in_entry;
    entry_t head_q;
    entry_t skid_q;

    // Handshakes use the registered ready/valid so neither side sees a comb path
    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        in_entry.result   = in_result;
        in_entry.zero     = in_zero;
        in_entry.negative = in_negative;
        in_entry.dest     = in_dest;
        in_entry.wr_en    = in_wr_en;
        in_entry.flags_en = in_flags_en;
    end

    exec_entry_reg u_head (
        .clock (clock),
        .reset (reset),
        .load  (head_load),
        .d     (head_in),
        .q     (head_q)
    );

    exec_entry_reg u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

    // Next state, entry steering, and retirement side effects
    always_comb begin
        state_d         = state_q;
        head_load       = 1'b0;
        skid_load       = 1'b0;
        head_in         = in_entry;
        flag_zero_d     = flag_zero_q;
        flag_negative_d = flag_negative_q;
        retire_count_d  = retire_count_q;

        if (flush) begin
            // Flush wins over any simultaneous push or pop
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                        state_d   = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        head_load = 1'b1;
                        head_in   = skid_q;
                        state_d   = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase

            if (pop) begin
                retire_count_d = retire_count_q + CNT_W'(1);
                if (head_q.flags_en) begin
                    flag_zero_d     = head_q.zero;
                    flag_negative_d = head_q.negative;
                end
            end
        end

        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= EMPTY;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            flag_zero_q     <= 1'b0;
            flag_negative_q <= 1'b0;
            retire_count_q  <= '0;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            flag_zero_q     <= flag_zero_d;
            flag_negative_q <= flag_negative_d;
            retire_count_q  <= retire_count_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_result    = head_q.result;
    assign out_dest      = head_q.dest;
    assign out_wr_en     = head_q.wr_en;
    assign flag_zero     = flag_zero_q;
    assign flag_negative = flag_negative_q;
    assign retire_count  = retire_count_q;

endmodule

// File: tb/tb_exec_result_buffer.sv
// Testbench for exec_result_buffer: directed vector table, queue-based
// reference model under streaming and random traffic, counter wrap and
// asynchronous reset mid-stream.
module tb_exec_result_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_zero;
    logic        in_negative;
    logic [4:0]  in_dest;
    logic        in_wr_en;
    logic        in_flags_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_wr_en;
    logic        flag_zero;
    logic        flag_negative;
    logic [15:0] retire_count;

    exec_result_buffer #(.CNT_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_zero       (in_zero),
        .in_negative   (in_negative),
        .in_dest       (in_dest),
        .in_wr_en      (in_wr_en),
        .in_flags_en   (in_flags_en),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_dest      (out_dest),
        .out_wr_en     (out_wr_en),
        .flag_zero     (flag_zero),
        .flag_negative (flag_negative),
        .retire_count  (retire_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: an in-order queue of at most 2 ----------------
    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        neg;
        logic [4:0]  dest;
        logic        wr_en;
        logic        flags_en;
    } mentry_t;

    mentry_t mq[$];
    logic    m_fz;
    logic    m_fn;
    int      m_cnt;
    bit      do_check = 1'b1;

    task automatic model_reset();
        mq.delete();
        m_fz  = 1'b0;
        m_fn  = 1'b0;
        m_cnt = 0;
    endtask

    function automatic mentry_t mk(input logic [31:0] r, input logic z, input logic n,
                                   input logic [4:0] d, input logic we, input logic fe);
        mentry_t e;
        e.result = r; e.zero = z; e.neg = n; e.dest = d; e.wr_en = we; e.flags_en = fe;
        return e;
    endfunction

    function automatic mentry_t rnd_entry();
        return mk($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    task automatic drive(input logic v, input mentry_t e, input logic fl, input logic ordy);
        in_valid    = v;
        in_result   = e.result;
        in_zero     = e.zero;
        in_negative = e.neg;
        in_dest     = e.dest;
        in_wr_en    = e.wr_en;
        in_flags_en = e.flags_en;
        flush       = fl;
        out_ready   = ordy;
    endtask

    // One clock of model-checked traffic; called and returns at a negedge
    task automatic cyc(input logic v, input mentry_t e, input logic fl, input logic ordy);
        mentry_t h;
        bit      can_push;
        drive(v, e, fl, ordy);
        if (do_check) begin
            chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
            chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_out_result", 64'(out_result), 64'(mq[0].result));
                chk("m_out_dest", 64'(out_dest), 64'(mq[0].dest));
                chk("m_out_wr_en", 64'(out_wr_en), 64'(mq[0].wr_en));
            end
            chk("m_flag_zero", 64'(flag_zero), 64'(m_fz));
            chk("m_flag_negative", 64'(flag_negative), 64'(m_fn));
            chk("m_retire_count", 64'(retire_count), 64'(m_cnt));
        end
        @(posedge clock);
        if (fl) begin
            mq.delete();
        end else begin
            can_push = (mq.size() < 2);
            if (ordy && mq.size() > 0) begin
                h     = mq.pop_front();
                m_cnt = (m_cnt + 1) % 65536;
                if (h.flags_en) begin
                    m_fz = h.zero;
                    m_fn = h.neg;
                end
            end
            if (v && can_push) mq.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_result"}, 64'(out_result), 64'd0);
        chk({tag, "_out_dest"}, 64'(out_dest), 64'd0);
        chk({tag, "_out_wr_en"}, 64'(out_wr_en), 64'd0);
        chk({tag, "_flag_zero"}, 64'(flag_zero), 64'd0);
        chk({tag, "_flag_negative"}, 64'(flag_negative), 64'd0);
        chk({tag, "_retire_count"}, 64'(retire_count), 64'd0);
    endtask

    task automatic apply_reset();
        drive(1'b0, mk(32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic [4:0]  d;
        logic        we;
        logic        fe;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_res;
        logic [4:0]  e_d;
        logic        e_we;
        logic        e_fz;
        logic        e_fn;
        int          e_cnt;
    } vec_t;

    vec_t vecs[15];

    initial begin
        mentry_t e;

        //            v     res           z     n     d      we    fe    fl    ordy   ir    ov    eres          ed     ewe   fz    fn    cnt
        vecs[0]  = '{1'b1, 32'h5,        1'b0, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1,  1'b1, 1'b1, 32'h5,        5'd3,  1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{1'b1, 32'h11,       1'b0, 1'b0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 32'h11,       5'd1,  1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{1'b1, 32'h22,       1'b1, 1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 32'h11,       5'd1,  1'b1, 1'b0, 1'b0, 1};
        vecs[4]  = '{1'b1, 32'h33,       1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 32'h11,       5'd1,  1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{1'b1, 32'h33,       1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 32'h22,       5'd2,  1'b1, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b1, 32'h33,       1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 32'h33,       5'd4,  1'b0, 1'b1, 1'b0, 3};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 32'h0,        5'd0,  1'b0, 1'b1, 1'b0, 4};
        vecs[8]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 32'hFFFFFFFF, 5'd9,  1'b1, 1'b1, 1'b0, 4};
        vecs[9]  = '{1'b1, 32'h0,        1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 32'h0,        5'd10, 1'b1, 1'b0, 1'b1, 5};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 32'h0,        5'd0,  1'b0, 1'b0, 1'b1, 6};
        vecs[11] = '{1'b1, 32'h77,       1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 32'h77,       5'd7,  1'b1, 1'b0, 1'b1, 6};
        vecs[12] = '{1'b1, 32'h88,       1'b1, 1'b1, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 32'h77,       5'd7,  1'b1, 1'b0, 1'b1, 6};
        vecs[13] = '{1'b1, 32'h99,       1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 32'h0,        5'd0,  1'b0, 1'b0, 1'b1, 6};
        vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 32'h0,        5'd0,  1'b0, 1'b0, 1'b1, 6};

        reset = 1'b0;
        model_reset();
        drive(1'b0, mk(32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check_reset_vals("por");
        reset = 1'b1;

        // Directed table: apply at negedge, check one cycle later
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, mk(vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].d, vecs[i].we, vecs[i].fe),
                  vecs[i].fl, vecs[i].ordy);
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_out_result", i), 64'(out_result), 64'(vecs[i].e_res));
                chk($sformatf("vec%0d_out_dest", i), 64'(out_dest), 64'(vecs[i].e_d));
                chk($sformatf("vec%0d_out_wr_en", i), 64'(out_wr_en), 64'(vecs[i].e_we));
            end
            chk($sformatf("vec%0d_flag_zero", i), 64'(flag_zero), 64'(vecs[i].e_fz));
            chk($sformatf("vec%0d_flag_negative", i), 64'(flag_negative), 64'(vecs[i].e_fn));
            chk($sformatf("vec%0d_retire_count", i), 64'(retire_count), 64'(vecs[i].e_cnt));
        end

        // Stream 100 entries at full rate, then drain
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, mk(32'(i * 7 + 1), 1'b0, 1'b0, 5'(i), 1'b1, 1'b0), 1'b0, 1'b1);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        cyc(1'b0, mk(32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b1);
        chk("stream_retire_count", 64'(retire_count), 64'd100);

        // Random traffic against the model
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            e = rnd_entry();
            cyc(1'($urandom_range(0, 3) != 0), e, 1'($urandom_range(0, 31) == 0),
                1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++)
            cyc(1'b0, mk(32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b1);

        // Counter wrap: 65535 retires, then one more
        apply_reset();
        do_check = 1'b0;
        for (int i = 0; i < 65535; i++)
            cyc(1'b1, mk(32'(i), 1'b0, 1'b0, 5'd1, 1'b1, 1'b0), 1'b0, 1'b1);
        cyc(1'b0, mk(32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b1);
        do_check = 1'b1;
        chk("wrap_pre_count", 64'(retire_count), 64'hFFFF);
        cyc(1'b1, mk(32'hABCD, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1), 1'b0, 1'b1);
        cyc(1'b0, mk(32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b1);
        chk("wrap_post_count", 64'(retire_count), 64'h0);
        chk("wrap_flag_negative", 64'(flag_negative), 64'd1);

        // Asynchronous reset with the buffer full and state non-zero
        cyc(1'b1, mk(32'h1234, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1), 1'b0, 1'b0);
        cyc(1'b1, mk(32'h5678, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1), 1'b0, 1'b0);
        chk("pre_reset_full", 64'(in_ready), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        cyc(1'b0, mk(32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b1);
        cyc(1'b0, mk(32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
